// File: rtl/recon_pkg.sv
// Shared helpers for the modulo-sampling reconstruction chain: Q-format constants
// and the internal arithmetic width used by the difference stages.
package recon_pkg;

  // Headroom for a second-order difference of WIDTH-bit samples plus folding.
  function automatic int unsigned int_width(input int unsigned width);
    return width + 32'd3;
  endfunction

  function automatic int q_one(input int unsigned frac_bits);
    return 32'sd1 <<< frac_bits;
  endfunction

  function automatic int lambda_to_q(input real lambda, input int unsigned frac_bits);
    return int'(lambda * real'(q_one(frac_bits)));
  endfunction

endpackage

// File: rtl/modulo_residual_diff_if.sv
// Sample-in / residual-out bundle for the modulo residual difference stage.
interface modulo_residual_diff_if #(
  parameter int unsigned WIDTH = 24
);
  logic                    clk_en;
  logic                    flush;
  logic                    valid_in;
  logic signed [WIDTH-1:0] sample_in;
  logic                    valid_out;
  logic signed [WIDTH-1:0] residual_diff_out;
  logic                    range_err;

  modport master (
    output clk_en, flush, valid_in, sample_in,
    input  valid_out, residual_diff_out, range_err
  );

  modport slave (
    input  clk_en, flush, valid_in, sample_in,
    output valid_out, residual_diff_out, range_err
  );
endinterface

// File: rtl/centred_fold_step.sv
// One registered centred-fold step: subtract/add STEP when the input leaves [-THR, THR),
// carrying a side value and a valid bit alongside.
module centred_fold_step #(
  parameter int unsigned W    = 27,
  parameter int          THR  = 1,
  parameter int          STEP = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_en_i,
  input  logic                flush_i,
  input  logic                valid_i,
  input  logic signed [W-1:0] data_i,
  input  logic signed [W-1:0] carry_i,
  output logic                valid_o,
  output logic signed [W-1:0] data_o,
  output logic signed [W-1:0] carry_o
);

  localparam logic signed [W-1:0] ThrPos = W'(THR);
  localparam logic signed [W-1:0] ThrNeg = W'(-THR);
  localparam logic signed [W-1:0] StepV  = W'(STEP);

  logic                valid_q;
  logic signed [W-1:0] data_q, data_d;
  logic signed [W-1:0] carry_q;

  always_comb begin
    data_d = data_i;
    if (data_i >= ThrPos) begin
      data_d = data_i - StepV;
    end else if (data_i < ThrNeg) begin
      data_d = data_i + StepV;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      carry_q <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      carry_q <= '0;
    end else if (clk_en_i) begin
      valid_q <= valid_i;
      data_q  <= data_d;
      carry_q <= carry_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign carry_o = carry_q;

endmodule

// File: rtl/modulo_residual_diff.sv
// Second-order difference of folded samples, centred-folded back into [-L, L); emits the
// residual M(d2) - d2, a multiple of 2L, three enabled cycles after each accepted sample.
module modulo_residual_diff
  import recon_pkg::*;
#(
  parameter int unsigned WIDTH           = 24,
  parameter int unsigned FRACTIONAL_BITS = 16,
  parameter int          LAMBDA_Q        = 49152
) (
  input logic                   clk,
  input logic                   reset,
  modulo_residual_diff_if.slave bus
);

  localparam int unsigned IW = int_width(WIDTH);
  localparam logic signed [WIDTH-1:0] LPos = WIDTH'(LAMBDA_Q);
  localparam logic signed [WIDTH-1:0] LNeg = WIDTH'(-LAMBDA_Q);

  if ((longint'(4) * longint'(LAMBDA_Q) >= (longint'(1) << (WIDTH - 1))) || (LAMBDA_Q <= 0) ||
      (FRACTIONAL_BITS >= WIDTH)) begin : g_bad_param
    $error("modulo_residual_diff: LAMBDA_Q out of range for WIDTH");
  end

  logic signed [IW-1:0] y_ext;
  logic signed [IW-1:0] y1_q, y1_d, y2_q, y2_d, d2_q, d2_d;
  logic [1:0]           wc_q, wc_d;
  logic                 v1_q, v1_d;
  logic                 range_err_q, range_err_d;
  logic                 out_of_range;

  logic                 v2, v3;
  logic signed [IW-1:0] t_s2, d2_s2, f_s3, d2_s3, res_full;
  logic                 unused_res_msb;

  assign y_ext        = {{(IW - WIDTH){bus.sample_in[WIDTH-1]}}, bus.sample_in};
  assign out_of_range = (bus.sample_in >= LPos) || (bus.sample_in < LNeg);

  always_comb begin
    y1_d        = y1_q;
    y2_d        = y2_q;
    d2_d        = d2_q;
    wc_d        = wc_q;
    v1_d        = v1_q;
    range_err_d = range_err_q;
    // Flush overrides both the enable and any sample presented this cycle.
    if (bus.flush) begin
      y1_d        = '0;
      y2_d        = '0;
      wc_d        = '0;
      v1_d        = 1'b0;
      range_err_d = 1'b0;
    end else if (bus.clk_en) begin
      v1_d = 1'b0;
      if (bus.valid_in) begin
        d2_d = y_ext - (y1_q <<< 1) + y2_q;
        y2_d = y1_q;
        y1_d = y_ext;
        v1_d = (wc_q == 2'd2);
        if (wc_q != 2'd2) begin
          wc_d = wc_q + 2'd1;
        end
        if (out_of_range) begin
          range_err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y1_q        <= '0;
      y2_q        <= '0;
      d2_q        <= '0;
      wc_q        <= '0;
      v1_q        <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      y1_q        <= y1_d;
      y2_q        <= y2_d;
      d2_q        <= d2_d;
      wc_q        <= wc_d;
      v1_q        <= v1_d;
      range_err_q <= range_err_d;
    end
  end

  centred_fold_step #(
    .W    (IW),
    .THR  (3 * LAMBDA_Q),
    .STEP (4 * LAMBDA_Q)
  ) u_coarse (
    .clk      (clk),
    .reset    (reset),
    .clk_en_i (bus.clk_en),
    .flush_i  (bus.flush),
    .valid_i  (v1_q),
    .data_i   (d2_q),
    .carry_i  (d2_q),
    .valid_o  (v2),
    .data_o   (t_s2),
    .carry_o  (d2_s2)
  );

  centred_fold_step #(
    .W    (IW),
    .THR  (LAMBDA_Q),
    .STEP (2 * LAMBDA_Q)
  ) u_fine (
    .clk      (clk),
    .reset    (reset),
    .clk_en_i (bus.clk_en),
    .flush_i  (bus.flush),
    .valid_i  (v2),
    .data_i   (t_s2),
    .carry_i  (d2_s2),
    .valid_o  (v3),
    .data_o   (f_s3),
    .carry_o  (d2_s3)
  );

  // Residual magnitude is at most 4L, so the narrowing below is lossless.
  assign res_full       = f_s3 - d2_s3;
  assign unused_res_msb = ^res_full[IW-1:WIDTH];

  assign bus.residual_diff_out = res_full[WIDTH-1:0];
  assign bus.valid_out         = v3;
  assign bus.range_err         = range_err_q;

endmodule

// File: tb/tb_modulo_residual_diff.sv
// Directed bench for modulo_residual_diff: vector table of sample triples plus
// stall, bubble, flush and range-error sequences.
module tb_modulo_residual_diff;

  localparam int unsigned W = 24;

  logic clk;
  logic reset;
  int   passed;
  int   total;
  int   consumed;

  modulo_residual_diff_if #(.WIDTH(W)) bus ();

  modulo_residual_diff #(
    .WIDTH           (W),
    .FRACTIONAL_BITS (16),
    .LAMBDA_Q        (49152)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    s0;
    int    s1;
    int    s2;
    int    res;
    bit    rerr;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic cyc(input bit en, input bit fl, input bit vi, input int s);
    bus.clk_en    = en;
    bus.flush     = fl;
    bus.valid_in  = vi;
    bus.sample_in = W'(s);
    #1;
    if (en && bus.valid_out) consumed++;
    @(posedge clk);
    #1;
  endtask

  function automatic int res_out();
    return int'(bus.residual_diff_out);
  endfunction

  task automatic run_vec(input vec_t v);
    cyc(1, 1, 0, 0);
    chk({v.name, " flush_rerr"}, int'(bus.range_err), 0);
    cyc(1, 0, 1, v.s0);
    chk({v.name, " warm0"}, int'(bus.valid_out), 0);
    cyc(1, 0, 1, v.s1);
    chk({v.name, " warm1"}, int'(bus.valid_out), 0);
    cyc(1, 0, 1, v.s2);
    chk({v.name, " lat1"}, int'(bus.valid_out), 0);
    cyc(1, 0, 0, 0);
    chk({v.name, " lat2"}, int'(bus.valid_out), 0);
    cyc(1, 0, 0, 0);
    chk({v.name, " valid"}, int'(bus.valid_out), 1);
    chk({v.name, " res"}, res_out(), v.res);
    chk({v.name, " rerr"}, int'(bus.range_err), int'(v.rerr));
    cyc(1, 0, 0, 0);
    chk({v.name, " drop"}, int'(bus.valid_out), 0);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    consumed = 0;
    vecs[0] = '{"zero",      0,      0,      0,       0,      1'b0};
    vecs[1] = '{"wrap_pos",  32768,  -32768, 32768,   -98304, 1'b0};
    vecs[2] = '{"extreme",   48000,  -49152, 48000,   -196608, 1'b0};
    vecs[3] = '{"wrap_neg",  -32768, 32768,  -32768,  98304,  1'b0};
    vecs[4] = '{"extr_neg",  -48000, 49151,  -48000,  196608, 1'b0};
    vecs[5] = '{"small",     1000,   2000,   500,     0,      1'b0};
    vecs[6] = '{"mid",       40000,  -10000, 40000,   -98304, 1'b0};
    vecs[7] = '{"t_eq_L",    20000,  -4576,  20000,   -98304, 1'b0};
    vecs[8] = '{"d2_eq_3L",  49000,  -24728, 49000,   -196608, 1'b0};
    vecs[9] = '{"t_eq_negL", -20000, 4576,   -20000,  0,      1'b0};

    reset         = 1'b1;
    bus.clk_en    = 1'b0;
    bus.flush     = 1'b0;
    bus.valid_in  = 1'b0;
    bus.sample_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset valid", int'(bus.valid_out), 0);
    chk("reset res", res_out(), 0);
    chk("reset rerr", int'(bus.range_err), 0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Stall with the result sitting in the second stage, then stall with it at the output.
    cyc(1, 1, 0, 0);
    cyc(1, 0, 1, 32768);
    cyc(1, 0, 1, -32768);
    cyc(1, 0, 1, 32768);
    cyc(1, 0, 0, 0);
    consumed = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 777);
      chk("stall1 valid", int'(bus.valid_out), 0);
    end
    cyc(1, 0, 0, 0);
    chk("stall out valid", int'(bus.valid_out), 1);
    chk("stall out res", res_out(), -98304);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0);
      chk("stall2 valid", int'(bus.valid_out), 1);
      chk("stall2 res", res_out(), -98304);
    end
    cyc(1, 0, 0, 0);
    chk("stall drop", int'(bus.valid_out), 0);
    chk("stall consumed", consumed, 1);

    // Bubbles between samples leave the history intact.
    cyc(1, 1, 0, 0);
    cyc(1, 0, 1, 32768);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 1, -32768);
    cyc(1, 0, 0, 0);
    chk("bubble warm", int'(bus.valid_out), 0);
    cyc(1, 0, 1, 32768);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("bubble valid", int'(bus.valid_out), 1);
    chk("bubble res", res_out(), -98304);

    // Flush with a sample while a result is in flight.
    cyc(1, 1, 0, 0);
    cyc(1, 0, 1, 32768);
    cyc(1, 0, 1, -32768);
    cyc(1, 0, 1, 32768);
    cyc(1, 0, 1, 0);
    cyc(1, 1, 1, 12345);
    chk("flush drop", int'(bus.valid_out), 0);
    cyc(1, 0, 1, 0);
    chk("flush warm0", int'(bus.valid_out), 0);
    cyc(1, 0, 1, 40000);
    chk("flush warm1", int'(bus.valid_out), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0);
      chk("flush idle", int'(bus.valid_out), 0);
    end
    cyc(1, 0, 1, -40000);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("flush resume valid", int'(bus.valid_out), 1);
    chk("flush resume res", res_out(), 98304);

    // Range error is sticky until flush; the offending sample is still processed.
    cyc(1, 1, 0, 0);
    cyc(1, 0, 1, 49152);
    chk("rerr set", int'(bus.range_err), 1);
    cyc(1, 0, 1, 0);
    cyc(1, 0, 1, 0);
    chk("rerr sticky", int'(bus.range_err), 1);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("rerr valid", int'(bus.valid_out), 1);
    chk("rerr res", res_out(), -98304);
    chk("rerr hold", int'(bus.range_err), 1);
    cyc(1, 1, 0, 0);
    chk("rerr flush", int'(bus.range_err), 0);
    cyc(1, 0, 1, -49153);
    chk("rerr neg", int'(bus.range_err), 1);
    cyc(0, 1, 0, 0);
    chk("rerr flush no en", int'(bus.range_err), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
